// File: rtl/sobel_window_feeder.sv
// sobel_window_feeder
// Accepts a raster-order pixel stream, keeps two line buffers and a sliding
// window, and hands every full 3x3 neighbourhood (centre excluded) to
// stochWrapper over the start/done handshake. Each result is written to a
// compact edge-memory port, and frame_done marks the last write of a frame.
// Optional build macro: DONE_TIMEOUT_EN adds a done watchdog of
// TIMEOUT_CYCLES cycles and the sticky timeout_err output.
module sobel_window_feeder #(
    parameter int IMG_COLS       = 576,
    parameter int IMG_ROWS       = 436,
    parameter int PIX_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int NUM_WIN       = (IMG_ROWS - 2) * (IMG_COLS - 2),
    localparam int ADDR_W        = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [PIX_W-1:0]  pixel_1_bin,
    output logic [PIX_W-1:0]  pixel_2_bin,
    output logic [PIX_W-1:0]  pixel_3_bin,
    output logic [PIX_W-1:0]  pixel_4_bin,
    output logic [PIX_W-1:0]  pixel_6_bin,
    output logic [PIX_W-1:0]  pixel_7_bin,
    output logic [PIX_W-1:0]  pixel_8_bin,
    output logic [PIX_W-1:0]  pixel_9_bin,
    output logic              start,
    input  logic              done,
    input  logic [PIX_W-1:0]  z_bin,
    output logic              edge_we,
    output logic [ADDR_W-1:0] edge_addr,
    output logic [PIX_W-1:0]  edge_data,
`ifdef DONE_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic              frame_done
);

    localparam int COL_W = $clog2(IMG_COLS);
    localparam int ROW_W = $clog2(IMG_ROWS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROWS - 1);

    // Reject geometries that cannot hold a single 3x3 neighbourhood.
    if (IMG_COLS < 3 || IMG_ROWS < 3 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("sobel_window_feeder: IMG_COLS/IMG_ROWS must be >= 3, TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ACCEPT  = 2'd0,
        LAUNCH  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // lb1 holds line r-2, lb0 holds line r-1 at the current column.
    logic [PIX_W-1:0] lb0 [IMG_COLS];
    logic [PIX_W-1:0] lb1 [IMG_COLS];

    // Sliding window, top row at index 0. Only the two older columns are
    // stored; the newest column is the line-buffer read plus pix_in, so the
    // complete neighbourhood can be registered on the accepting edge itself.
    logic [PIX_W-1:0] win_mid   [3];
    logic [PIX_W-1:0] win_right [3];

    logic [PIX_W-1:0] col_top;
    logic [PIX_W-1:0] col_centre;
    logic             accept;
    logic             win_done;
    logic             done_q;
    logic             done_rise;
    logic             launch_exit;
    logic             last_win;

    assign accept     = pix_valid && pix_ready;
    assign col_top    = lb1[col];
    assign col_centre = lb0[col];
    assign win_done   = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign done_rise  = done && !done_q;

`ifdef DONE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit     = (state == LAUNCH) && !done_rise &&
                         (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign launch_exit = done_rise || tmo_hit;

    // Watchdog: counts LAUNCH cycles, latches timeout_err until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == LAUNCH && !launch_exit) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign launch_exit = done_rise;
`endif

    // FSM state register; asynchronous reset returns start high at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACCEPT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: one window in flight, pixels stall while it computes.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCEPT:  if (win_done)    state_nxt = LAUNCH;
            LAUNCH:  if (launch_exit) state_nxt = CAPTURE;
            CAPTURE: state_nxt = ACCEPT;
            default: state_nxt = ACCEPT;
        endcase
    end

    // FSM outputs: handshake and strobes decoded directly from state.
    always_comb begin
        pix_ready  = 1'b0;
        start      = 1'b1;
        edge_we    = 1'b0;
        frame_done = 1'b0;
        case (state)
            ACCEPT:  pix_ready = 1'b1;
            LAUNCH:  start = 1'b0;
            CAPTURE: begin
                edge_we    = 1'b1;
                frame_done = last_win;
            end
            default: ;
        endcase
    end

    // Raster counters, window shift, window output register and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col         <= '0;
            row         <= '0;
            done_q      <= 1'b0;
            last_win    <= 1'b0;
            edge_addr   <= '0;
            edge_data   <= '0;
            pixel_1_bin <= '0;
            pixel_2_bin <= '0;
            pixel_3_bin <= '0;
            pixel_4_bin <= '0;
            pixel_6_bin <= '0;
            pixel_7_bin <= '0;
            pixel_8_bin <= '0;
            pixel_9_bin <= '0;
            for (int i = 0; i < 3; i++) begin
                win_mid[i]   <= '0;
                win_right[i] <= '0;
            end
        end else begin
            done_q <= done;

            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    win_mid[i] <= win_right[i];
                end
                win_right[0] <= col_top;
                win_right[1] <= col_centre;
                win_right[2] <= pix_in;

                // Wrapping past the last line restarts the raster at (0,0).
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            if (win_done) begin
                pixel_1_bin <= win_mid[0];
                pixel_2_bin <= win_right[0];
                pixel_3_bin <= col_top;
                pixel_4_bin <= win_mid[1];
                pixel_6_bin <= col_centre;
                pixel_7_bin <= win_mid[2];
                pixel_8_bin <= win_right[2];
                pixel_9_bin <= pix_in;
                last_win    <= (row == ROW_LAST) && (col == COL_LAST);
            end

            // A watchdog expiry writes zero in place of a result.
            if (state == LAUNCH && launch_exit) begin
                edge_data <= done_rise ? z_bin : '0;
            end

            // Windows complete in raster order, so the compact index is a count.
            if (state == CAPTURE) begin
                edge_addr <= last_win ? '0 : edge_addr + ADDR_W'(1);
            end
        end
    end

    // Line buffers: each column moves one line up as a new pixel arrives.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_in;
        end
    end

endmodule
